// File: rtl/mdu_if.sv
// mdu_if: EX-stage <-> mdu_seq handshake and data bus.
// master = pipeline side, slave = mdu_seq.
interface mdu_if;
  logic [2:0]  op_i;
  logic [31:0] rs_i;
  logic [31:0] rt_i;
  logic [63:0] prod_i;
  logic [63:0] hilo_i;
  logic        annul_i;
  logic        stall_o;
  logic        whilo_o;
  logic [63:0] hilo_o;
  logic        done_o;

  modport master (
    output op_i, rs_i, rt_i, prod_i, hilo_i, annul_i,
    input  stall_o, whilo_o, hilo_o, done_o
  );

  modport slave (
    input  op_i, rs_i, rt_i, prod_i, hilo_i, annul_i,
    output stall_o, whilo_o, hilo_o, done_o
  );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle MADD/MSUB accumulate and radix-2 restoring divider
// sitting beside EX. Stalls the pipeline while busy, then writes HI/LO for
// one cycle.
// Optional build macro: MDU_DIV_EARLY_EN -- finish a divide on issue when the
// dividend magnitude is below the divisor magnitude.
module mdu_seq #(
  parameter int unsigned DIV_STEPS = 32
) (
  input  logic clk,
  input  logic rst,
  mdu_if.slave bus
);

  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = (DIV_STEPS > 1) ? $clog2(DIV_STEPS) : 1;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MADD  = 3'b001;
  localparam logic [2:0] OP_MADDU = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_MSUBU = 3'b100;
  localparam logic [2:0] OP_DIV   = 3'b101;
  localparam logic [2:0] OP_DIVU  = 3'b110;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MACC = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      acc_q, acc_d;
  logic [63:0]      res_q, res_d;
  logic [DW-1:0]    rem_q, rem_d;
  logic [DW-1:0]    quot_q, quot_d;
  logic [DW-1:0]    dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             mac_q, mac_d;

  logic          is_mac_c, is_sub_c, is_div_c, is_sdiv_c, start_c;
  logic [DW-1:0] mag_rs_c, mag_rt_c;
  logic [DW:0]   shift_c, trial_c;
  logic [DW-1:0] rem_n_c, quot_n_c;
  logic          stall_c, whilo_c;
  logic [63:0]   hilo_c;

  // Opcode decode; 111 and 000 are both idle.
  always_comb begin
    is_mac_c  = 1'b0;
    is_sub_c  = 1'b0;
    is_div_c  = 1'b0;
    is_sdiv_c = 1'b0;
    case (bus.op_i)
      OP_MADD, OP_MADDU: is_mac_c = 1'b1;
      OP_MSUB, OP_MSUBU: begin
        is_mac_c = 1'b1;
        is_sub_c = 1'b1;
      end
      OP_DIV: begin
        is_div_c  = 1'b1;
        is_sdiv_c = 1'b1;
      end
      OP_DIVU: is_div_c = 1'b1;
      OP_NONE: ;
      default: ;
    endcase
    start_c = (is_mac_c | is_div_c) & ~bus.annul_i;
  end

  // Operand magnitudes; 0x80000000 negates to itself and reads as unsigned.
  always_comb begin
    mag_rs_c = (is_sdiv_c && bus.rs_i[DW-1]) ? (~bus.rs_i + 32'd1) : bus.rs_i;
    mag_rt_c = (is_sdiv_c && bus.rt_i[DW-1]) ? (~bus.rt_i + 32'd1) : bus.rt_i;
  end

  // One restoring step: shift {rem,quot} left, trial-subtract the divisor.
  always_comb begin
    shift_c = {rem_q, quot_q[DW-1]};
    trial_c = shift_c - {1'b0, dvs_q};
    if (!trial_c[DW]) begin
      rem_n_c  = trial_c[DW-1:0];
      quot_n_c = {quot_q[DW-2:0], 1'b1};
    end else begin
      rem_n_c  = shift_c[DW-1:0];
      quot_n_c = {quot_q[DW-2:0], 1'b0};
    end
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    mac_d   = mac_q;
    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          if (is_mac_c) begin
            acc_d   = is_sub_c ? (~bus.prod_i + 64'd1) : bus.prod_i;
            mac_d   = 1'b1;
            state_d = S_DONE;
          end else if (bus.rt_i == 32'd0) begin
            res_d   = 64'h0;
            mac_d   = 1'b0;
            state_d = S_DONE;
`ifdef MDU_DIV_EARLY_EN
          end else if (mag_rs_c < mag_rt_c) begin
            res_d   = {bus.rs_i, 32'h0};
            mac_d   = 1'b0;
            state_d = S_DONE;
`endif
          end else begin
            rem_d   = 32'd0;
            quot_d  = mag_rs_c;
            dvs_d   = mag_rt_c;
            qneg_d  = is_sdiv_c & (bus.rs_i[DW-1] ^ bus.rt_i[DW-1]);
            rneg_d  = is_sdiv_c & bus.rs_i[DW-1];
            cnt_d   = '0;
            mac_d   = 1'b0;
            state_d = S_DIV;
          end
        end
      end
      S_MACC: begin
        state_d = S_DONE;
      end
      S_DIV: begin
        rem_d  = rem_n_c;
        quot_d = quot_n_c;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
          res_d   = {rneg_q ? (~rem_n_c + 32'd1) : rem_n_c,
                     qneg_q ? (~quot_n_c + 32'd1) : quot_n_c};
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (bus.annul_i) begin
      state_d = S_IDLE;
    end
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      mac_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      mac_q   <= mac_d;
    end
  end

  // Stall and HI/LO write; the accumulate add uses hilo_i as seen in DONE.
  always_comb begin
    stall_c = 1'b0;
    whilo_c = 1'b0;
    hilo_c  = 64'h0;
    if (!rst) begin
      case (state_q)
        S_IDLE: stall_c = start_c;
        S_MACC, S_DIV: stall_c = ~bus.annul_i;
        S_DONE: begin
          if (!bus.annul_i) begin
            whilo_c = 1'b1;
            hilo_c  = mac_q ? (bus.hilo_i + acc_q) : res_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_o = stall_c;
  assign bus.whilo_o = whilo_c;
  assign bus.hilo_o  = hilo_c;
  assign bus.done_o  = whilo_c;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed test of mdu_seq with a per-cycle reference model.
module tb_mdu_seq;

  logic clk;
  logic rst;
  mdu_if bus();

  mdu_seq #(.DIV_STEPS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

`ifdef MDU_DIV_EARLY_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: quotient truncates toward zero, remainder follows dividend sign.
  function automatic logic [63:0] div_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return 64'h0;
    if (op == 3'b101) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  function automatic int div_lat(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    logic [31:0] ma, mb;
    if (b == 32'd0) return 1;
    ma = (op == 3'b101 && a[31]) ? -a : a;
    mb = (op == 3'b101 && b[31]) ? -b : b;
`ifdef MDU_DIV_EARLY_EN
    if (ma < mb) return 1;
`endif
    return 33;
  endfunction

  // Per-cycle model: one pending op with a due cycle and its result.
  bit          m_pend = 0;
  bit          m_mac;
  int          m_due;
  longint      cyc = 0;
  logic [63:0] m_acc, m_res;

  always @(negedge clk) begin
    bit          vop, e_stall, e_whilo;
    logic [63:0] e_hilo;
    if (rst) begin
      m_pend = 0;
    end else begin
      vop = (bus.op_i >= 3'd1) && (bus.op_i <= 3'd6);
      e_stall = 0;
      e_whilo = 0;
      e_hilo  = 64'h0;
      if (!m_pend) begin
        e_stall = vop && !bus.annul_i;
      end else if (cyc == m_due) begin
        e_whilo = !bus.annul_i;
        if (e_whilo) e_hilo = m_mac ? bus.hilo_i + m_acc : m_res;
      end else begin
        e_stall = !bus.annul_i;
      end
      chk("model stall_o", 64'(bus.stall_o), 64'(e_stall));
      chk("model whilo_o", 64'(bus.whilo_o), 64'(e_whilo));
      chk("model done_o", 64'(bus.done_o), 64'(e_whilo));
      if (e_whilo || !m_pend) chk("model hilo_o", bus.hilo_o, e_hilo);
      if (m_pend) begin
        if (bus.annul_i || cyc == m_due) m_pend = 0;
      end else if (vop && !bus.annul_i) begin
        m_pend = 1;
        if (bus.op_i <= 3'd4) begin
          m_mac = 1;
          m_acc = (bus.op_i >= 3'd3) ? -bus.prod_i : bus.prod_i;
          m_due = int'(cyc) + 1;
        end else begin
          m_mac = 0;
          m_res = div_ref(bus.op_i, bus.rs_i, bus.rt_i);
          m_due = int'(cyc) + div_lat(bus.op_i, bus.rs_i, bus.rt_i);
        end
      end
    end
    cyc++;
  end

  // Issue one op at the current cycle and wait for its write.
  task automatic run(input string nm, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] hl,
                     input logic [63:0] exp, input int exp_lat);
    int k;
    bit got;
    longint sa, sb;
    bus.op_i = op;
    bus.rs_i = a;
    bus.rt_i = b;
    bus.hilo_i = hl;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 3'b001 || op == 3'b011) bus.prod_i = 64'(sa * sb);
    else bus.prod_i = {32'h0, a} * {32'h0, b};
    k = 0;
    got = 0;
    while (!got && k < 40) begin
      @(negedge clk);
      if (bus.whilo_o) begin
        got = 1;
        chk({nm, " latency"}, 64'(k), 64'(exp_lat));
        chk({nm, " hilo_o"}, bus.hilo_o, exp);
      end
      @(posedge clk);
      #1;
      k++;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: no whilo_o within 40 cycles, required one", nm);
    end
    bus.op_i = 3'b000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.op_i = 3'b000;
    bus.rs_i = '0;
    bus.rt_i = '0;
    bus.prod_i = '0;
    bus.hilo_i = '0;
    bus.annul_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset stall_o", 64'(bus.stall_o), 64'd0);
    chk("reset whilo_o", 64'(bus.whilo_o), 64'd0);
    chk("reset hilo_o", bus.hilo_o, 64'h0);
    chk("reset done_o", 64'(bus.done_o), 64'd0);
    @(posedge clk);
    #1;

    run("madd", 3'b001, 32'd3, 32'd4, 64'd5, 64'h11, 1);
    run("msubu", 3'b100, 32'd3, 32'd4, 64'd0, 64'hFFFF_FFFF_FFFF_FFF4, 1);
    run("madd neg", 3'b001, 32'hFFFF_FFFE, 32'd3, 64'd10, 64'd4, 1);
    run("maddu wrap", 3'b010, 32'd1, 32'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1);
    run("msub neg", 3'b011, 32'hFFFF_FFFE, 32'd3, 64'd0, 64'd6, 1);
    run("div -7/2", 3'b101, 32'hFFFF_FFF9, 32'd2, 64'd0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run("divu ff/10", 3'b110, 32'hFFFF_FFFF, 32'h10, 64'd0, {32'h0000_000F, 32'h0FFF_FFFF}, 33);
    run("divu by0", 3'b110, 32'h1234, 32'd0, 64'd0, 64'h0, 1);
    run("div by0", 3'b101, 32'hFFFF_0000, 32'd0, 64'd7, 64'h0, 1);
    run("div 100/-7", 3'b101, 32'd100, 32'hFFFF_FFF9, 64'd0, {32'd2, 32'hFFFF_FFF2}, 33);
    run("div min/-1", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, {32'd0, 32'h8000_0000}, 33);
    run("divu min/3", 3'b110, 32'h8000_0000, 32'd3, 64'd0, {32'd2, 32'h2AAA_AAAA}, 33);
    run("div 3/7", 3'b101, 32'd3, 32'd7, 64'd0, {32'd3, 32'd0}, EARLY_LAT);
    run("div -3/7", 3'b101, 32'hFFFF_FFFD, 32'd7, 64'd0, {32'hFFFF_FFFD, 32'd0}, EARLY_LAT);

    // Annul a divide ten cycles in, then a MADD two cycles later.
    bus.op_i = 3'b101;
    bus.rs_i = 32'd100;
    bus.rt_i = 32'd7;
    repeat (10) @(posedge clk);
    #1 bus.annul_i = 1'b1;
    @(negedge clk);
    chk("annul stall_o", 64'(bus.stall_o), 64'd0);
    chk("annul whilo_o", 64'(bus.whilo_o), 64'd0);
    @(posedge clk);
    #1 bus.annul_i = 1'b0;
    bus.op_i = 3'b000;
    @(negedge clk);
    chk("annul+1 whilo_o", 64'(bus.whilo_o), 64'd0);
    chk("annul+1 stall_o", 64'(bus.stall_o), 64'd0);
    @(posedge clk);
    #1;
    run("madd after annul", 3'b001, 32'd3, 32'd4, 64'd5, 64'h11, 1);

    // Reset in the middle of a divide.
    bus.op_i = 3'b101;
    bus.rs_i = 32'hFFFF_FFF9;
    bus.rt_i = 32'd2;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.op_i = 3'b000;
    @(negedge clk);
    chk("rst mid stall_o", 64'(bus.stall_o), 64'd0);
    chk("rst mid whilo_o", 64'(bus.whilo_o), 64'd0);
    chk("rst mid hilo_o", bus.hilo_o, 64'h0);
    repeat (40) @(posedge clk);
    #1;
    run("divu after rst", 3'b110, 32'd100, 32'd7, 64'd0, {32'd2, 32'd14}, 33);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
